// File: rtl/rega_pkg.sv
// Shared types for the irrigation/fertigation controller.
//   state_t   : controller FSM states, 3-bit encoding
//   LVL_*     : tank level codes as {nv1,nv0}
package rega_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    FILL  = 3'd1,
    MIX   = 3'd2,
    SERVE = 3'd3,
    CLEAN = 3'd4,
    FAULT = 3'd5
  } state_t;

  localparam logic [1:0] LVL_EMPTY = 2'b00;
  localparam logic [1:0] LVL_PART  = 2'b01;
  localparam logic [1:0] LVL_FULL  = 2'b11;
  localparam logic [1:0] LVL_BAD   = 2'b10;  // top wet, bottom dry: broken sensor

endpackage

// File: rtl/rega_rr_arb.sv
// Combinational round-robin selector.
//   req : per-zone request vector
//   ptr : zone with highest priority this cycle
//   gnt : first requesting zone at or after ptr (wrapping)
//   vld : at least one request present
module rega_rr_arb #(
  parameter  int ZONES = 4,
  localparam int ZW    = $clog2(ZONES)
) (
  input  logic [ZONES-1:0] req,
  input  logic [ZW-1:0]    ptr,
  output logic [ZW-1:0]    gnt,
  output logic             vld
);

  logic [ZW-1:0] j;

  // Scan from the farthest offset down so the nearest requester wins last.
  always_comb begin
    gnt = '0;
    vld = 1'b0;
    j   = '0;
    for (int i = ZONES - 1; i >= 0; i--) begin
      j = ZW'((int'(ptr) + i) % ZONES);
      if (req[j]) begin
        gnt = j;
        vld = 1'b1;
      end
    end
  end

endmodule

// File: rtl/rega_zonas_adub.sv
// Multi-zone irrigation/fertigation controller: tank refill, optional
// fertilizer mixing, round-robin time-sliced zone service and a timed
// cleaning flush after fertilized cycles. Sticky FAULT on a bad level code.
//   clk, reset     : clock, async active-low reset
//   adub           : fertilizer request, latched when leaving IDLE
//   nv1, nv0       : tank upper/lower level sensors
//   zone_req       : per-zone irrigation requests
//   fault_clr      : leave FAULT (only with a valid level code)
//   ve, mist, limp : inlet valve, mixer, cleaning flush
//   zone_valve     : one-hot drive of the served zone
//   cur_zone       : zone served / last served
//   busy, fault    : status
module rega_zonas_adub
  import rega_pkg::*;
#(
  parameter  int ZONES     = 4,
  parameter  int MIX_CYC   = 50,
  parameter  int SLICE_CYC = 200,
  parameter  int CLEAN_CYC = 100,
  parameter  int TW        = 16,
  localparam int ZW        = $clog2(ZONES)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             adub,
  input  logic             nv1,
  input  logic             nv0,
  input  logic [ZONES-1:0] zone_req,
  input  logic             fault_clr,
  output logic             ve,
  output logic             mist,
  output logic             limp,
  output logic [ZONES-1:0] zone_valve,
  output logic [ZW-1:0]    cur_zone,
  output logic             busy,
  output logic             fault
);

  state_t        state, nxt;
  logic [TW-1:0] tmr;
  logic [ZW-1:0] rr_ptr, arb_ptr, nz, gnt;
  logic          gnt_vld, fert;
  logic          rot, fert_ld, fert_clr;

  logic [1:0] lvl;
  logic       lvl_bad, lvl_empty, lvl_full, any_req;
  logic       mix_done, slice_done, clean_done;

  assign lvl        = {nv1, nv0};
  assign lvl_bad    = (lvl == LVL_BAD);
  assign lvl_empty  = (lvl == LVL_EMPTY);
  assign lvl_full   = (lvl == LVL_FULL);
  assign any_req    = |zone_req;
  assign mix_done   = (tmr == TW'(MIX_CYC - 1));
  assign slice_done = (tmr == TW'(SLICE_CYC - 1));
  assign clean_done = (tmr == TW'(CLEAN_CYC - 1));

  // Zone after the current one, wrapping; used as the pointer on rotation.
  assign nz      = (cur_zone == ZW'(ZONES - 1)) ? '0 : cur_zone + ZW'(1);
  // On rotation the arbiter must already see the advanced pointer so the
  // new grant lands in the same cycle the timer reloads.
  assign arb_ptr = rot ? nz : rr_ptr;

  rega_rr_arb #(.ZONES(ZONES)) u_arb (
    .req (zone_req),
    .ptr (arb_ptr),
    .gnt (gnt),
    .vld (gnt_vld)
  );

  always_comb begin
    nxt      = state;
    rot      = 1'b0;
    fert_ld  = 1'b0;
    fert_clr = 1'b0;
    if (lvl_bad) begin
      nxt = FAULT;
    end else begin
      case (state)
        IDLE: if (any_req) begin
          fert_ld = 1'b1;
          if (lvl_empty) nxt = FILL;
          else if (adub) nxt = MIX;
          else           nxt = SERVE;
        end
        FILL: if (lvl_full) begin
          if (fert)         nxt = MIX;
          else if (any_req) nxt = SERVE;
          else              nxt = IDLE;
        end
        MIX: begin
          if (lvl_empty)     nxt = FILL;
          else if (mix_done) nxt = any_req ? SERVE : CLEAN;
        end
        SERVE: begin
          if (lvl_empty)                              nxt = FILL;
          else if (!any_req)                          nxt = fert ? CLEAN : IDLE;
          else if (slice_done || !zone_req[cur_zone]) rot = 1'b1;
        end
        CLEAN: if (clean_done) begin
          nxt      = IDLE;
          fert_clr = 1'b1;
        end
        FAULT: if (fault_clr) begin
          nxt      = IDLE;
          fert_clr = 1'b1;
        end
        default: nxt = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state    <= IDLE;
      tmr      <= '0;
      fert     <= 1'b0;
      rr_ptr   <= '0;
      cur_zone <= '0;
    end else begin
      state <= nxt;
      tmr   <= (nxt != state || rot) ? '0 : tmr + TW'(1);
      if (fert_ld)       fert <= adub;
      else if (fert_clr) fert <= 1'b0;
      if (rot) rr_ptr <= nz;
      if (((nxt == SERVE) && (state != SERVE)) || rot)
        if (gnt_vld) cur_zone <= gnt;
    end
  end

  // Actuators are pure decodes of the registered state.
  assign ve    = (state == FILL) || (state == CLEAN);
  assign mist  = (state == MIX);
  assign limp  = (state == CLEAN);
  assign busy  = (state != IDLE) && (state != FAULT);
  assign fault = (state == FAULT);

  always_comb begin
    zone_valve = '0;
    if (state == SERVE) zone_valve[cur_zone] = 1'b1;
  end

endmodule

// File: tb/tb_rega_zonas_adub.sv
module tb_rega_zonas_adub;

  localparam int ZONES = 4;

  logic             clk, reset, adub, nv1, nv0, fault_clr;
  logic [ZONES-1:0] zone_req, zone_valve;
  logic             ve, mist, limp, busy, fault;
  logic [1:0]       cur_zone;

  int ncmp = 0;
  int nerr = 0;
  int exp_q[$];

  rega_zonas_adub #(
    .ZONES(ZONES), .MIX_CYC(3), .SLICE_CYC(4), .CLEAN_CYC(5), .TW(16)
  ) dut (
    .clk(clk), .reset(reset), .adub(adub), .nv1(nv1), .nv0(nv0),
    .zone_req(zone_req), .fault_clr(fault_clr), .ve(ve), .mist(mist),
    .limp(limp), .zone_valve(zone_valve), .cur_zone(cur_zone),
    .busy(busy), .fault(fault)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "timeout");
  end

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic setlvl(input logic [1:0] l);
    {nv1, nv0} = l;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    ncmp++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  initial begin
    int n, e;
    logic [ZONES-1:0] vec;

    reset = 1'b0; adub = 1'b0; fault_clr = 1'b0;
    setlvl(2'b00); zone_req = 4'b0001;
    #12;
    chk("rst_ve",    32'(ve), 32'(0));
    chk("rst_busy",  32'(busy), 32'(0));
    chk("rst_fault", 32'(fault), 32'(0));
    chk("rst_zv",    32'(zone_valve), 32'(0));
    chk("rst_cz",    32'(cur_zone), 32'(0));
    step(1);
    reset = 1'b1;

    // empty tank with a request -> fill, then serve zone 0
    step(1);
    chk("fill_ve",   32'(ve), 32'(1));
    chk("fill_busy", 32'(busy), 32'(1));
    setlvl(2'b11);
    step(1);
    chk("serve0_zv", 32'(zone_valve), 32'(4'b0001));
    chk("serve0_cz", 32'(cur_zone), 32'(0));
    chk("serve0_ve", 32'(ve), 32'(0));
    zone_req = 4'b0000;
    step(1);
    chk("idle_busy", 32'(busy), 32'(0));

    // fertilized cycle: 3 cycles of mixing, serve zone 2, 5 cycles of cleaning
    adub = 1'b1; zone_req = 4'b0100;
    step(1);
    adub = 1'b0;
    n = 0;
    while (mist === 1'b1 && n < 20) begin n++; step(1); end
    chk("mix_len",    32'(n), 32'(3));
    chk("serve2_zv",  32'(zone_valve), 32'(4'b0100));
    chk("serve2_cz",  32'(cur_zone), 32'(2));
    zone_req = 4'b0000;
    step(1);
    n = 0;
    while (limp === 1'b1 && ve === 1'b1 && n < 20) begin n++; step(1); end
    chk("clean_len",  32'(n), 32'(5));
    chk("clean_busy", 32'(busy), 32'(0));
    chk("clean_ve",   32'(ve), 32'(0));

    // round robin over 1011: 0,1,3,0 with 4-cycle slices
    zone_req = 4'b1011;
    exp_q.push_back(0); exp_q.push_back(1); exp_q.push_back(3); exp_q.push_back(0);
    step(1);
    for (int k = 0; k < 4; k++) begin
      e = exp_q.pop_front();
      chk("grant_cz", 32'(cur_zone), 32'(e));
      chk("grant_zv", 32'(zone_valve), 32'(1 << e));
      vec = zone_valve;
      n = 0;
      while (zone_valve === vec && n < 10) begin
        n++; step(1);
        chk("onehot", 32'($onehot(zone_valve)), 32'(1));
      end
      chk("slice_len", 32'(n), 32'(4));
    end

    // zone 1 now in service: empty tank interrupts, pointer kept
    exp_q.push_back(1);
    setlvl(2'b00);
    step(1);
    chk("refill_zv",   32'(zone_valve), 32'(0));
    chk("refill_ve",   32'(ve), 32'(1));
    setlvl(2'b11);
    step(1);
    e = exp_q.pop_front();
    chk("resume_cz",   32'(cur_zone), 32'(e));
    chk("resume_zv",   32'(zone_valve), 32'(1 << e));

    // bad level during mixing -> sticky fault
    zone_req = 4'b0000;
    step(1);
    adub = 1'b1; zone_req = 4'b0001;
    step(1);
    adub = 1'b0;
    chk("fmix_mist",   32'(mist), 32'(1));
    setlvl(2'b10);
    step(1);
    chk("fault_f",     32'(fault), 32'(1));
    chk("fault_act",   32'({ve, mist, limp, busy}), 32'(0));
    chk("fault_zv",    32'(zone_valve), 32'(0));
    zone_req = 4'b0000; fault_clr = 1'b1;
    step(1);
    chk("fault_stick", 32'(fault), 32'(1));
    setlvl(2'b01);
    step(1);
    chk("fault_exit",  32'(fault), 32'(0));
    chk("fexit_busy",  32'(busy), 32'(0));
    fault_clr = 1'b0;

    // async reset in the middle of cleaning
    setlvl(2'b11); adub = 1'b1; zone_req = 4'b0100;
    step(1);
    adub = 1'b0;
    step(3);
    chk("pre_cz",      32'(cur_zone), 32'(2));
    zone_req = 4'b0000;
    step(1);
    chk("pre_limp",    32'(limp), 32'(1));
    step(1);
    #2 reset = 1'b0;
    #1;
    chk("arst_act",    32'({ve, mist, limp, busy, fault}), 32'(0));
    chk("arst_cz",     32'(cur_zone), 32'(0));
    #3 reset = 1'b1;
    step(2);
    chk("post_busy",   32'(busy), 32'(0));
    chk("post_cz",     32'(cur_zone), 32'(0));
    chk("post_fault",  32'(fault), 32'(0));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nerr);
    $finish;
  end

endmodule
